// File: rtl/datapath_sequencer.sv
// Multi-cycle MiniSRC control FSM: fetch into IR, decode, drive one datapath phase per state.
// Latency (zero-wait): nop 2, ALU 5, st 4, ld 6, mul/div 3, br/jr 3, jal 6 cycles; memory strobes held until iMemReady.
// Backpressure: FETCH/MEM stall on iMemReady up to MEM_TIMEOUT cycles, then fault-halt. Illegal-op trap: DPSEQ_ILLEGAL_TRAP_EN.
module datapath_sequencer #(
    parameter int OPC_W       = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] iMemData,
    input  logic        iMemReady,
    output logic        oMemRead,
    output logic        oMemWrite,
    input  logic        iJ_zero,
    input  logic        iJ_nZero,
    input  logic        iJ_pos,
    input  logic        iJ_neg,
    output logic        oPC_nRst,
    output logic        oPC_en,
    output logic        oPC_jmp,
    output logic        oPC_loadRA,
    output logic        oPC_loadImm,
    output logic        oRF_Write,
    output logic [3:0]  oRF_AddrA,
    output logic [3:0]  oRF_AddrB,
    output logic [3:0]  oRF_AddrC,
    output logic        oRWB_en,
    output logic        oRA_en,
    output logic        oRB_en,
    output logic        oRZH_en,
    output logic        oRZL_en,
    output logic        oRAS_en,
    output logic [3:0]  oALU_Ctrl,
    output logic        oMUX_BIS,
    output logic        oMUX_RZHS,
    output logic        oMUX_WBM,
    output logic        oMUX_MAP,
    output logic        oMUX_ASS,
    output logic        oMUX_WBP,
    output logic [31:0] oImm32,
    output logic        oHalted,
    output logic        oFault
);

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_WRITE, S_BRANCH, S_HALT
    } state_t;

    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_ROR  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_ROL  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_SHR  = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_SHRA = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_SHL  = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(12);
    localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(13);
    localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(15);
    localparam logic [OPC_W-1:0] OP_DIV  = OPC_W'(16);
    localparam logic [OPC_W-1:0] OP_NEG  = OPC_W'(17);
    localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'(18);
    localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(19);
    localparam logic [OPC_W-1:0] OP_JR   = OPC_W'(20);
    localparam logic [OPC_W-1:0] OP_JAL  = OPC_W'(21);
    localparam logic [OPC_W-1:0] OP_MFHI = OPC_W'(24);
    localparam logic [OPC_W-1:0] OP_MFLO = OPC_W'(25);
    localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(26);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(27);

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [7:0]  wait_q, wait_d;
    logic        fault_q, fault_d;
    logic        link_q, link_d;

    logic [OPC_W-1:0] opc;
    logic [3:0]       ra, rb, rc, alu_code;
    logic             uses_imm, legal, br_take, timeout;
    logic             is_ld, is_st, is_br, is_jr, is_jal, is_mfhi, is_mflo, is_muldiv;

    assign opc       = ir_q[31 -: OPC_W];
    assign ra        = ir_q[26:23];
    assign rb        = ir_q[22:19];
    assign rc        = ir_q[18:15];
    assign is_ld     = (opc == OP_LD);
    assign is_st     = (opc == OP_ST);
    assign is_br     = (opc == OP_BR);
    assign is_jr     = (opc == OP_JR);
    assign is_jal    = (opc == OP_JAL);
    assign is_mfhi   = (opc == OP_MFHI);
    assign is_mflo   = (opc == OP_MFLO);
    assign is_muldiv = (opc == OP_MUL) || (opc == OP_DIV);
    assign timeout   = (wait_q == TMO_LAST);

    assign oRF_AddrC = ra;
    assign oRF_AddrA = rb;
    assign oRF_AddrB = (is_st || is_br || is_jr || is_jal) ? ra : rc;
    assign oImm32    = {{13{ir_q[18]}}, ir_q[18:0]};
    assign oFault    = fault_q;

    always_comb begin
        alu_code = 4'd0;
        uses_imm = 1'b0;
        legal    = 1'b1;
        case (opc)
            OP_LD, OP_LDI, OP_ST, OP_ADDI: uses_imm = 1'b1;
            OP_ADD:  alu_code = 4'd0;
            OP_SUB:  alu_code = 4'd1;
            OP_AND:  alu_code = 4'd2;
            OP_OR:   alu_code = 4'd3;
            OP_ROR:  alu_code = 4'd4;
            OP_ROL:  alu_code = 4'd5;
            OP_SHR:  alu_code = 4'd6;
            OP_SHRA: alu_code = 4'd7;
            OP_SHL:  alu_code = 4'd8;
            OP_ANDI: begin alu_code = 4'd2; uses_imm = 1'b1; end
            OP_ORI:  begin alu_code = 4'd3; uses_imm = 1'b1; end
            OP_MUL:  alu_code = 4'd9;
            OP_DIV:  alu_code = 4'd10;
            OP_NEG:  alu_code = 4'd11;
            OP_NOT:  alu_code = 4'd12;
            OP_BR, OP_JR, OP_JAL, OP_MFHI, OP_MFLO, OP_NOP, OP_HALT: ;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        case (ir_q[20:19])
            2'b00:   br_take = iJ_zero;
            2'b01:   br_take = iJ_nZero;
            2'b10:   br_take = iJ_pos;
            default: br_take = iJ_neg;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        wait_d      = 8'd0;
        fault_d     = fault_q;
        link_d      = link_q;
        oMemRead    = 1'b0;
        oMemWrite   = 1'b0;
        oPC_nRst    = 1'b1;
        oPC_en      = 1'b0;
        oPC_jmp     = 1'b0;
        oPC_loadRA  = 1'b0;
        oPC_loadImm = 1'b0;
        oRF_Write   = 1'b0;
        oRWB_en     = 1'b0;
        oRA_en      = 1'b0;
        oRB_en      = 1'b0;
        oRZH_en     = 1'b0;
        oRZL_en     = 1'b0;
        oRAS_en     = 1'b0;
        oALU_Ctrl   = 4'd0;
        oMUX_BIS    = 1'b0;
        oMUX_RZHS   = 1'b0;
        oMUX_WBM    = 1'b0;
        oMUX_MAP    = 1'b1;
        oMUX_ASS    = 1'b0;
        oMUX_WBP    = 1'b0;
        oHalted     = 1'b0;
        case (state_q)
            S_RST: begin
                oPC_nRst = 1'b0;
                state_d  = S_FETCH;
            end
            S_FETCH: begin
                oMemRead = 1'b1;
                link_d   = 1'b0;
                if (iMemReady) begin
                    ir_d    = iMemData;
                    oPC_en  = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                oRA_en = 1'b1;
                oRB_en = 1'b1;
                if (!legal) begin
`ifdef DPSEQ_ILLEGAL_TRAP_EN
                    fault_d = 1'b1;
                    state_d = S_HALT;
`else
                    state_d = S_FETCH;
`endif
                end else if (opc == OP_NOP) begin
                    state_d = S_FETCH;
                end else if (opc == OP_HALT) begin
                    state_d = S_HALT;
                end else if (is_br || is_jr || is_jal) begin
                    state_d = S_BRANCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                oALU_Ctrl = alu_code;
                oMUX_BIS  = uses_imm;
                if (is_muldiv) begin
                    oRAS_en = 1'b1;
                    state_d = S_FETCH;
                end else if (is_mfhi || is_mflo) begin
                    state_d = S_WB;
                end else begin
                    oRZL_en = 1'b1;
                    state_d = (is_ld || is_st) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                oMUX_MAP  = 1'b0;
                oMemRead  = is_ld;
                oMemWrite = !is_ld;
                if (iMemReady) begin
                    // Loaded data is captured straight into the write-back register here.
                    oMUX_WBM = is_ld;
                    oRWB_en  = is_ld;
                    state_d  = is_ld ? S_WB : S_FETCH;
                end else if (timeout) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                oRWB_en   = !is_ld;
                oMUX_ASS  = is_mfhi || is_mflo;
                oMUX_RZHS = is_mfhi;
                oMUX_WBP  = is_jal;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                oRF_Write = 1'b1;
                state_d   = is_jal ? S_BRANCH : S_FETCH;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
                if (is_br) begin
                    oPC_jmp     = br_take;
                    oPC_loadImm = br_take;
                end else if (is_jal && !link_q) begin
                    // Link is written back first; the jump happens on the second visit.
                    link_d  = 1'b1;
                    state_d = S_WB;
                end else begin
                    oPC_jmp    = 1'b1;
                    oPC_loadRA = 1'b1;
                end
            end
            S_HALT: oHalted = 1'b1;
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_RST;
            ir_q    <= 32'd0;
            wait_q  <= 8'd0;
            fault_q <= 1'b0;
            link_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            link_q  <= link_d;
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: directed steps plus random instructions checked against a per-opcode event model.
// Outputs are sampled 1 time unit after the falling edge; iMemReady is driven per cycle from the strobes.
module tb_datapath_sequencer;

    logic        iClk, iRst, iMemReady, oMemRead, oMemWrite;
    logic [31:0] iMemData, oImm32;
    logic        iJ_zero, iJ_nZero, iJ_pos, iJ_neg;
    logic        oPC_nRst, oPC_en, oPC_jmp, oPC_loadRA, oPC_loadImm, oRF_Write;
    logic [3:0]  oRF_AddrA, oRF_AddrB, oRF_AddrC, oALU_Ctrl;
    logic        oRWB_en, oRA_en, oRB_en, oRZH_en, oRZL_en, oRAS_en;
    logic        oMUX_BIS, oMUX_RZHS, oMUX_WBM, oMUX_MAP, oMUX_ASS, oMUX_WBP;
    logic        oHalted, oFault;

    datapath_sequencer dut (
        .iClk(iClk), .iRst(iRst), .iMemData(iMemData), .iMemReady(iMemReady),
        .oMemRead(oMemRead), .oMemWrite(oMemWrite),
        .iJ_zero(iJ_zero), .iJ_nZero(iJ_nZero), .iJ_pos(iJ_pos), .iJ_neg(iJ_neg),
        .oPC_nRst(oPC_nRst), .oPC_en(oPC_en), .oPC_jmp(oPC_jmp), .oPC_loadRA(oPC_loadRA),
        .oPC_loadImm(oPC_loadImm), .oRF_Write(oRF_Write),
        .oRF_AddrA(oRF_AddrA), .oRF_AddrB(oRF_AddrB), .oRF_AddrC(oRF_AddrC),
        .oRWB_en(oRWB_en), .oRA_en(oRA_en), .oRB_en(oRB_en), .oRZH_en(oRZH_en),
        .oRZL_en(oRZL_en), .oRAS_en(oRAS_en), .oALU_Ctrl(oALU_Ctrl),
        .oMUX_BIS(oMUX_BIS), .oMUX_RZHS(oMUX_RZHS), .oMUX_WBM(oMUX_WBM),
        .oMUX_MAP(oMUX_MAP), .oMUX_ASS(oMUX_ASS), .oMUX_WBP(oMUX_WBP),
        .oImm32(oImm32), .oHalted(oHalted), .oFault(oFault)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    localparam int BUDGET = 2000;

    int n_cmp = 0;
    int n_err = 0;
    int alu_of [32];
    int legal_ops [25];

    // Observations of one instruction, from its FETCH to the next FETCH (or halt).
    int o_cyc, o_wr, o_ras, o_rzl, o_jmp, o_limm, o_lra, o_rd, o_wt, o_wbm, o_wbp, o_rwb;
    int o_alu, o_bis, o_asr, o_addrc, o_addra, o_addrb, o_imm, o_wrcyc, o_halt, o_fault;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic do_reset();
        iRst      = 1'b1;
        iMemReady = 1'b0;
        repeat (3) @(negedge iClk);
        #1;
        chk("reset_ctl", int'({oMemRead, oMemWrite, oPC_nRst, oPC_en, oPC_jmp, oPC_loadRA,
                               oPC_loadImm, oRF_Write, oRWB_en, oRA_en, oRB_en, oRZH_en,
                               oRZL_en, oRAS_en, oMUX_BIS, oMUX_RZHS, oMUX_WBM, oMUX_MAP,
                               oMUX_ASS, oMUX_WBP, oHalted, oFault}), 32'h10);
        chk("reset_addr_alu", int'({oALU_Ctrl, oRF_AddrA, oRF_AddrB, oRF_AddrC}), 0);
        chk("reset_imm", int'(oImm32), 0);
        iRst = 1'b0;
        @(negedge iClk);
        #1;
        chk("fetch_after_rst", int'({oMemRead, oPC_nRst}), 3);
    endtask

    // Entered at negedge+1 with the DUT in FETCH; returns at negedge+1 of the next FETCH or HALT.
    task automatic run_instr(input logic [31:0] w, input int fw, input int mw);
        int  fwd, mwd;
        bit  fetched, r;
        fwd = 0; mwd = 0; fetched = 0;
        o_cyc = 0; o_wr = 0; o_ras = 0; o_rzl = 0; o_jmp = 0; o_limm = 0; o_lra = 0;
        o_rd = 0; o_wt = 0; o_wbm = 0; o_wbp = 0; o_rwb = 0;
        o_alu = -1; o_bis = -1; o_asr = -1; o_addrc = -1; o_addra = -1; o_addrb = -1;
        o_imm = -1; o_wrcyc = -1;
        iMemData = w;
        forever begin
            if (fetched && oMemRead && oMUX_MAP) break;
            if (oHalted) break;
            if (o_cyc >= BUDGET) begin
                n_cmp++;
                n_err++;
                $error("FAIL run_budget: observed %0d cycles without completion, limit %0d", o_cyc, BUDGET);
                break;
            end
            if (oMemRead || oMemWrite) begin
                if (oMUX_MAP) begin r = (fwd >= fw); fwd++; end
                else          begin r = (mwd >= mw); mwd++; end
            end else begin
                r = 1'($urandom_range(0, 1));
            end
            iMemReady = r;
            #1;
            o_cyc++;
            if (oRF_Write) begin o_wr++; o_addrc = oRF_AddrC; o_wrcyc = o_cyc; end
            if (oRAS_en) o_ras++;
            if (oRZL_en) o_rzl++;
            if (oRAS_en || oRZL_en) begin o_alu = oALU_Ctrl; o_bis = oMUX_BIS; end
            if (oPC_jmp) o_jmp++;
            if (oPC_loadImm) o_limm++;
            if (oPC_loadRA) o_lra++;
            if (oMemRead) o_rd++;
            if (oMemWrite) o_wt++;
            if (oRWB_en) begin
                o_rwb++;
                o_asr = int'({oMUX_ASS, oMUX_RZHS});
                if (oMUX_WBM) o_wbm++;
                if (oMUX_WBP) o_wbp++;
            end
            if (oRA_en) begin o_addra = oRF_AddrA; o_addrb = oRF_AddrB; o_imm = int'(oImm32); end
            if (oPC_en) fetched = 1;
            @(negedge iClk);
            iMemReady = 1'b0;
            #1;
        end
        o_halt  = oHalted;
        o_fault = oFault;
    endtask

    // Reference: expected event counts per instruction class, from the opcode table and cycle counts.
    task automatic check_instr(input logic [31:0] w, input int fw, input int mw);
        int  opc, ra, rb, rc, lat, v;
        int  e_wr, e_ras, e_rzl, e_jmp, e_limm, e_lra, e_rd, e_wt, e_wbm, e_wbp;
        int  e_alu, e_bis, e_asr, e_addrc, e_halt, e_fault;
        bit  cond, writer;
        opc = int'(w[31:27]); ra = int'(w[26:23]); rb = int'(w[22:19]); rc = int'(w[18:15]);
        case (w[20:19])
            2'b00:   cond = iJ_zero;
            2'b01:   cond = iJ_nZero;
            2'b10:   cond = iJ_pos;
            default: cond = iJ_neg;
        endcase
        e_wr = 0; e_ras = 0; e_rzl = 0; e_jmp = 0; e_limm = 0; e_lra = 0; e_wt = 0;
        e_wbm = 0; e_wbp = 0; e_halt = 0; e_fault = 0; e_asr = -1; writer = 0;
        e_rd = 1 + fw;
        if (opc == 0) begin
            lat = 6 + mw; e_rzl = 1; writer = 1; e_wbm = 1; e_rd = e_rd + 1 + mw; e_asr = 0;
        end else if (opc == 2) begin
            lat = 4 + mw; e_rzl = 1; e_wt = 1 + mw;
        end else if (opc inside {1, [3:14], 17, 18}) begin
            lat = 5; e_rzl = 1; writer = 1; e_asr = 0;
        end else if (opc == 15 || opc == 16) begin
            lat = 3; e_ras = 1;
        end else if (opc == 24 || opc == 25) begin
            lat = 5; writer = 1; e_asr = (opc == 24) ? 3 : 2;
        end else if (opc == 19) begin
            lat = 3; e_jmp = int'(cond); e_limm = int'(cond);
        end else if (opc == 20) begin
            lat = 3; e_jmp = 1; e_lra = 1;
        end else if (opc == 21) begin
            lat = 6; e_jmp = 1; e_lra = 1; writer = 1; e_wbp = 1; e_asr = 0;
        end else if (opc == 26) begin
            lat = 2;
        end else if (opc == 27) begin
            lat = 2; e_halt = 1;
        end else begin
            lat = 2;
`ifdef DPSEQ_ILLEGAL_TRAP_EN
            e_halt = 1; e_fault = 1;
`endif
        end
        lat = lat + fw;
        e_alu = (e_rzl + e_ras > 0) ? alu_of[opc] : -1;
        e_bis = (e_rzl + e_ras > 0) ? int'(opc inside {0, 1, 2, 12, 13, 14}) : -1;
        e_wr    = int'(writer);
        e_addrc = writer ? ra : -1;
        v = int'(w[18:0]);
        if (v >= 262144) v = v - 524288;
        chk($sformatf("cycles op%0d", opc), o_cyc, lat);
        chk($sformatf("rf_write op%0d", opc), o_wr, e_wr);
        chk($sformatf("ras_en op%0d", opc), o_ras, e_ras);
        chk($sformatf("rzl_en op%0d", opc), o_rzl, e_rzl);
        chk($sformatf("pc_jmp op%0d", opc), o_jmp, e_jmp);
        chk($sformatf("pc_loadimm op%0d", opc), o_limm, e_limm);
        chk($sformatf("pc_loadra op%0d", opc), o_lra, e_lra);
        chk($sformatf("mem_read_cyc op%0d", opc), o_rd, e_rd);
        chk($sformatf("mem_write_cyc op%0d", opc), o_wt, e_wt);
        chk($sformatf("wbm_rwb op%0d", opc), o_wbm, e_wbm);
        chk($sformatf("wbp_rwb op%0d", opc), o_wbp, e_wbp);
        chk($sformatf("rwb_en op%0d", opc), o_rwb, e_wr);
        chk($sformatf("alu_ctrl op%0d", opc), o_alu, e_alu);
        chk($sformatf("mux_bis op%0d", opc), o_bis, e_bis);
        chk($sformatf("ass_rzhs op%0d", opc), o_asr, e_asr);
        chk($sformatf("addr_c op%0d", opc), o_addrc, e_addrc);
        chk($sformatf("addr_a op%0d", opc), o_addra, rb);
        chk($sformatf("addr_b op%0d", opc), o_addrb, (opc inside {2, 19, 20, 21}) ? ra : rc);
        chk($sformatf("imm32 op%0d", opc), o_imm, v);
        chk($sformatf("halted op%0d", opc), o_halt, e_halt);
        chk($sformatf("fault op%0d", opc), o_fault, e_fault);
    endtask

    logic [31:0] w;
    int          fw, mw;

    initial begin
        foreach (alu_of[i]) alu_of[i] = -1;
        alu_of[0] = 0;  alu_of[1] = 0;  alu_of[2] = 0;  alu_of[3] = 0;  alu_of[4] = 1;
        alu_of[5] = 2;  alu_of[6] = 3;  alu_of[7] = 4;  alu_of[8] = 5;  alu_of[9] = 6;
        alu_of[10] = 7; alu_of[11] = 8; alu_of[12] = 0; alu_of[13] = 2; alu_of[14] = 3;
        alu_of[15] = 9; alu_of[16] = 10; alu_of[17] = 11; alu_of[18] = 12;
        for (int i = 0; i < 22; i++) legal_ops[i] = i;
        legal_ops[22] = 24; legal_ops[23] = 25; legal_ops[24] = 26;

        iRst = 1'b1; iMemReady = 1'b0; iMemData = 32'd0;
        {iJ_zero, iJ_nZero, iJ_pos, iJ_neg} = 4'b0000;
        do_reset();

        // add r1,r1,r0: write strobe lands in the fifth cycle
        run_instr(32'h18880000, 0, 0);
        check_instr(32'h18880000, 0, 0);
        chk("add_write_cycle", o_wrcyc, 5);

        // ld r2,4(r3) with three wait cycles in MEM
        run_instr(32'h01180004, 0, 3);
        check_instr(32'h01180004, 0, 3);
        chk("ld_write_cycle", o_wrcyc, 9);

        // br zero taken, then not taken
        iJ_zero = 1'b1;
        run_instr(32'h98800010, 0, 0);
        check_instr(32'h98800010, 0, 0);
        iJ_zero = 1'b0;
        run_instr(32'h98800010, 0, 0);
        check_instr(32'h98800010, 0, 0);

        // mul then mfhi
        run_instr(32'h7A2B0000, 0, 0);
        check_instr(32'h7A2B0000, 0, 0);
        run_instr(32'hC3800000, 0, 0);
        check_instr(32'hC3800000, 0, 0);

        for (int k = 0; k < 80; k++) begin
            w  = {5'(legal_ops[$urandom_range(0, 24)]), 27'($urandom)};
            fw = $urandom_range(0, 3);
            mw = $urandom_range(0, 3);
            {iJ_zero, iJ_nZero, iJ_pos, iJ_neg} = 4'($urandom);
            run_instr(w, fw, mw);
            check_instr(w, fw, mw);
        end

        // illegal opcode 31
        run_instr(32'hF8000000, 1, 0);
        check_instr(32'hF8000000, 1, 0);
`ifdef DPSEQ_ILLEGAL_TRAP_EN
        do_reset();
`endif

        // halt is terminal and ignores memory handshakes
        run_instr(32'hD8000000, 0, 0);
        check_instr(32'hD8000000, 0, 0);
        repeat (6) begin
            @(negedge iClk);
            iMemReady = 1'($urandom_range(0, 1));
            #1;
        end
        chk("halt_sticky", int'({oHalted, oMemRead, oMemWrite}), 4);
        do_reset();

        // reset in the middle of a store aborts the write strobe
        iMemData = 32'h11880008;
        for (int c = 0; c < 10 && !oMemWrite; c++) begin
            iMemReady = oMemRead;
            @(negedge iClk);
            iMemReady = 1'b0;
            #1;
        end
        chk("st_in_mem", int'(oMemWrite), 1);
        iRst = 1'b1;
        @(negedge iClk);
        #1;
        chk("midop_rst_strobes", int'({oMemRead, oMemWrite, oPC_nRst}), 0);
        iRst = 1'b0;
        @(negedge iClk);
        #1;
        chk("midop_rst_refetch", int'({oMemRead, oPC_nRst}), 3);

        // fetch never completes: 255 read cycles, then fault-halt
        run_instr(32'h18880000, 100000, 0);
        chk("timeout_read_cycles", o_rd, 255);
        chk("timeout_halted", o_halt, 1);
        chk("timeout_fault", o_fault, 1);
        chk("timeout_strobes", int'({oMemRead, oMemWrite}), 0);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
